// File: rtl/buffer_handoff_ctrl.sv
// -----------------------------------------------------------------------------
// buffer_handoff_ctrl
//
// Ownership controller for the three packet buffers (ping, pang, pong) of one
// packet-filter core. Each buffer rotates snooper -> CPU -> forwarder -> free.
// Packet arrival order is preserved by mod-4 sequence tags. The CPU and the
// forwarder are always handed the oldest waiting packet, whatever buffer it
// sits in.
//
// Ports
//   clk        core clock
//   rst_n      synchronous, active-low reset
//   sn_done    pulse: snooper finished writing its packet
//   cpu_acc    pulse: CPU accepts its packet (wins over cpu_rej)
//   cpu_rej    pulse: CPU rejects its packet
//   fwd_done   pulse: forwarder finished reading its packet
//   sn_sel, cpu_sel, fwd_sel      buffer owned by agent (00 none, 01 ping,
//                                 10 pang, 11 pong)
//   ping_sel, pang_sel, pong_sel  agent owning buffer (00 none, 01 snooper,
//                                 10 CPU, 11 forwarder)
//   sn_rdy, cpu_rdy, fwd_rdy      agent currently owns a buffer
//
// All outputs are decoded only from registered state, so there is no
// combinational path from any input to any output.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module buffer_handoff_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sn_done,
    input  logic       cpu_acc,
    input  logic       cpu_rej,
    input  logic       fwd_done,
    output logic [1:0] sn_sel,
    output logic [1:0] cpu_sel,
    output logic [1:0] fwd_sel,
    output logic [1:0] ping_sel,
    output logic [1:0] pang_sel,
    output logic [1:0] pong_sel,
    output logic       sn_rdy,
    output logic       cpu_rdy,
    output logic       fwd_rdy
);

    localparam int NUM_BUFS = 3;

    typedef enum logic [2:0] {
        B_EMPTY,
        B_SN_OWN,
        B_WAIT_CPU,
        B_CPU_OWN,
        B_WAIT_FWD,
        B_FWD_OWN
    } buf_state_t;

    buf_state_t state_q [NUM_BUFS];
    buf_state_t state_d [NUM_BUFS];
    logic [1:0] tag_q   [NUM_BUFS];
    logic [1:0] tag_d   [NUM_BUFS];

    logic [1:0] cpu_tag_ctr_q, cpu_tag_ctr_d;
    logic [1:0] cpu_next_q,    cpu_next_d;
    logic [1:0] fwd_tag_ctr_q, fwd_tag_ctr_d;
    logic [1:0] fwd_next_q,    fwd_next_d;

    logic                sn_busy, cpu_busy, fwd_busy;
    logic [NUM_BUFS-1:0] sn_pick, cpu_pick, fwd_pick;
    logic                sn_found;
    logic                cpu_grant, fwd_grant;

    // -------------------------------------------------------------------------
    // State registers. The buffer state/tag arrays are only three entries of
    // control state, so they are reset along with the counters: a reset must
    // abandon every ownership immediately.
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_BUFS; i++) begin
                state_q[i] <= B_EMPTY;
                tag_q[i]   <= 2'd0;
            end
            cpu_tag_ctr_q <= 2'd0;
            cpu_next_q    <= 2'd0;
            fwd_tag_ctr_q <= 2'd0;
            fwd_next_q    <= 2'd0;
        end else begin
            for (int i = 0; i < NUM_BUFS; i++) begin
                state_q[i] <= state_d[i];
                tag_q[i]   <= tag_d[i];
            end
            cpu_tag_ctr_q <= cpu_tag_ctr_d;
            cpu_next_q    <= cpu_next_d;
            fwd_tag_ctr_q <= fwd_tag_ctr_d;
            fwd_next_q    <= fwd_next_d;
        end
    end

    // -------------------------------------------------------------------------
    // Grant selection and next-state logic, all from pre-edge state. Because
    // a buffer only becomes grantable in its pre-edge state, a buffer released
    // at one edge can be granted at the next edge at the earliest.
    // -------------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        sn_busy   = 1'b0;
        cpu_busy  = 1'b0;
        fwd_busy  = 1'b0;
        sn_pick   = '0;
        cpu_pick  = '0;
        fwd_pick  = '0;
        sn_found  = 1'b0;

        for (int i = 0; i < NUM_BUFS; i++) begin
            if (state_q[i] == B_SN_OWN)  sn_busy  = 1'b1;
            if (state_q[i] == B_CPU_OWN) cpu_busy = 1'b1;
            if (state_q[i] == B_FWD_OWN) fwd_busy = 1'b1;
            // Snooper takes the lowest-index free buffer.
            if (state_q[i] == B_EMPTY && !sn_found) begin
                sn_pick[i] = 1'b1;
                sn_found   = 1'b1;
            end
            // Tags of waiting buffers are unique, so at most one matches.
            if (state_q[i] == B_WAIT_CPU && tag_q[i] == cpu_next_q) cpu_pick[i] = 1'b1;
            if (state_q[i] == B_WAIT_FWD && tag_q[i] == fwd_next_q) fwd_pick[i] = 1'b1;
        end

        cpu_grant = !cpu_busy && (cpu_pick != '0);
        fwd_grant = !fwd_busy && (fwd_pick != '0);

        for (int i = 0; i < NUM_BUFS; i++) begin
            state_d[i] = state_q[i];
            tag_d[i]   = tag_q[i];
            case (state_q[i])
                B_EMPTY:    if (!sn_busy && sn_pick[i]) state_d[i] = B_SN_OWN;
                B_SN_OWN:   if (sn_done) begin
                                state_d[i] = B_WAIT_CPU;
                                tag_d[i]   = cpu_tag_ctr_q;
                            end
                B_WAIT_CPU: if (!cpu_busy && cpu_pick[i]) state_d[i] = B_CPU_OWN;
                B_CPU_OWN:  if (cpu_acc) begin
                                state_d[i] = B_WAIT_FWD;
                                tag_d[i]   = fwd_tag_ctr_q;
                            end else if (cpu_rej) begin
                                state_d[i] = B_EMPTY;
                            end
                B_WAIT_FWD: if (!fwd_busy && fwd_pick[i]) state_d[i] = B_FWD_OWN;
                B_FWD_OWN:  if (fwd_done) state_d[i] = B_EMPTY;
                default:    state_d[i] = B_EMPTY;
            endcase
        end

        // Pulses from an agent that owns nothing leave the counters alone.
        cpu_tag_ctr_d = cpu_tag_ctr_q + {1'b0, sn_busy && sn_done};
        fwd_tag_ctr_d = fwd_tag_ctr_q + {1'b0, cpu_busy && cpu_acc};
        cpu_next_d    = cpu_next_q + {1'b0, cpu_grant};
        fwd_next_d    = fwd_next_q + {1'b0, fwd_grant};
    end

    // -------------------------------------------------------------------------
    // Output decode from registered buffer state. Both views come from the same
    // state_q entries, so agent and buffer selects can never disagree.
    // -------------------------------------------------------------------------
    logic [1:0] buf_agent [NUM_BUFS];

    always_comb begin
        sn_sel  = 2'b00;
        cpu_sel = 2'b00;
        fwd_sel = 2'b00;
        for (int i = 0; i < NUM_BUFS; i++) begin
            buf_agent[i] = 2'b00;
            case (state_q[i])
                B_SN_OWN:  begin buf_agent[i] = 2'b01; sn_sel  = 2'(i + 1); end
                B_CPU_OWN: begin buf_agent[i] = 2'b10; cpu_sel = 2'(i + 1); end
                B_FWD_OWN: begin buf_agent[i] = 2'b11; fwd_sel = 2'(i + 1); end
                default:   ;
            endcase
        end
    end

    assign ping_sel = buf_agent[0];
    assign pang_sel = buf_agent[1];
    assign pong_sel = buf_agent[2];

    assign sn_rdy  = (sn_sel  != 2'b00);
    assign cpu_rdy = (cpu_sel != 2'b00);
    assign fwd_rdy = (fwd_sel != 2'b00);

endmodule

// File: doc/buffer_handoff_ctrl.md
# buffer_handoff_ctrl

Ownership controller for the three packet buffers (ping, pang, pong) of one packet-filter core. It rotates each buffer through snooper → CPU → forwarder and back to free, preserving packet arrival order. It drives the six 2-bit select lines that steer agent and buffer traffic through the core's agent/buffer crossbar, plus a per-agent "you own a buffer" flag.

## Interface
- Parameters: none. Buffer count is fixed at 3 by the 2-bit select encoding.
- clk  in  1  core clock
- rst_n  in  1  synchronous, active-low reset
- sn_done  in  1  pulse: snooper finished writing its packet
- cpu_acc  in  1  pulse: CPU accepts the packet it holds
- cpu_rej  in  1  pulse: CPU rejects the packet it holds
- fwd_done  in  1  pulse: forwarder finished reading its packet
- sn_sel, cpu_sel, fwd_sel  out  2 each  buffer owned by that agent: 00 none, 01 ping, 10 pang, 11 pong
- ping_sel, pang_sel, pong_sel  out  2 each  agent owning that buffer: 00 none, 01 snooper, 10 CPU, 11 forwarder
- sn_rdy, cpu_rdy, fwd_rdy  out  1 each  agent currently owns a buffer (sel != 00)

## Operation
- Per-buffer state register, one of: EMPTY, SN_OWN, WAIT_CPU, CPU_OWN, WAIT_FWD, FWD_OWN.
- Release transitions, applied on the edge where the owner's pulse is sampled high:
  - SN_OWN → WAIT_CPU
  - CPU_OWN → WAIT_FWD on cpu_acc
  - CPU_OWN → EMPTY on cpu_rej
  - FWD_OWN → EMPTY on fwd_done
- cpu_acc and cpu_rej high together: treated as accept.
- A pulse from an agent that owns nothing is ignored; it has no other effect.
- Grant rules are evaluated on pre-edge state only. An agent owning nothing before the edge receives at most one buffer at that edge:
  - Snooper: lowest-index EMPTY buffer (ping > pang > pong).
  - CPU: oldest WAIT_CPU buffer.
  - Forwarder: oldest WAIT_FWD buffer.
- A buffer moves at most one state per edge. A buffer released at edge E is grantable at E+1 at the earliest.
- Ordering:
  - Each buffer carries a 2-bit tag.
  - On SN_OWN → WAIT_CPU it receives cpu_tag_ctr, which then increments mod 4.
  - The CPU is granted the WAIT_CPU buffer whose tag equals cpu_next; cpu_next increments on grant.
  - On accept the buffer is retagged from fwd_tag_ctr. fwd_next selects and advances the same way.
  - At most 3 packets are in flight, so mod-4 tags are unambiguous.
- All select and rdy outputs are registered, or decoded purely from registered state. No combinational path from inputs to outputs.
- The ping/pang/pong selects and the sn/cpu/fwd selects are always mutually consistent: buffer X reports agent A iff A reports X.

## Timing
- Reset (rst_n low at an edge): all buffers EMPTY, all tags and counters 0, every select 00, every rdy 0.
- First edge with rst_n high: ping → SN_OWN, so sn_sel = 01 and ping_sel = 01 in the following cycle.
- sn_done sampled at edge E: sn_rdy = 0 after E. If an EMPTY buffer existed before E, snooper is regranted at E+1. If the CPU was idle, the CPU is granted this buffer at E+1. Minimum sn_done → cpu_rdy latency is 2 edges.
- cpu_acc at E: cpu_rdy low after E; forwarder grant at E+1 if the forwarder is idle.
- cpu_rej or fwd_done at E: buffer EMPTY after E; snooper grant at E+1 at the earliest.
- All buffers busy: sn_rdy stays 0 until a buffer becomes EMPTY. Back-pressure to the packet source is upstream's job.
- Simultaneous pulses from different agents at one edge are all honoured independently.
- Reset asserted mid-operation: all ownership is abandoned at that edge and the outputs take their reset values. Buffer contents are not this block's concern.

## Test plan
- Reset, then idle → after the first edge: sn_sel = 01, ping_sel = 01, all others 00, cpu_rdy = fwd_rdy = 0.
- sn_done at E1, cpu_acc 3 cycles later, fwd_done 3 cycles after that → ping follows SN→CPU→FWD→EMPTY; cpu_sel = 01 exactly 2 edges after E1; snooper holds pang from E1+1.
- Three sn_done with the CPU holding the first packet → snooper idle (sn_sel = 00) with ping CPU_OWN and pang, pong WAIT_CPU; cpu_rej on ping → ping EMPTY, CPU then gets pang (the older), snooper gets ping next edge.
- Packets written in order pang, pong, ping (forced by rejects), all accepted, forwarder stalled → forwarder receives them in that exact order.
- cpu_acc and cpu_rej in the same cycle → buffer goes to WAIT_FWD. fwd_done while fwd_sel = 00 → no state change.
- rst_n low during FWD_OWN with other buffers in WAIT_CPU → all selects 00 next cycle; release → ping regranted to snooper.
